// File: rtl/calc_n_core_if.sv
// Request/response bundle of calc_n_core: per-port command/operand lanes in,
// per-port response, result, busy and drop lanes out.
interface calc_n_core_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
);
    logic [4*NUM_PORTS-1:0]      req_cmd_in;
    logic [DATA_W*NUM_PORTS-1:0] req_data_in;
    logic [2*NUM_PORTS-1:0]      out_resp;
    logic [DATA_W*NUM_PORTS-1:0] out_data;
    logic [NUM_PORTS-1:0]        busy;
    logic [NUM_PORTS-1:0]        cmd_drop;

    modport master (
        output req_cmd_in, req_data_in,
        input  out_resp, out_data, busy, cmd_drop
    );

    modport slave (
        input  req_cmd_in, req_data_in,
        output out_resp, out_data, busy, cmd_drop
    );
endinterface

// File: rtl/calc_n_core.sv
// Multi-port calculator core: per-port two-cycle operand capture, round-robin
// arbitration onto one registered ALU, response on the issuing port's lanes.
module calc_n_core #(
    parameter  int NUM_PORTS = 4,
    parameter  int DATA_W    = 32,
    localparam int SH_W      = $clog2(DATA_W)
) (
    input logic         c_clk,
    input logic         reset_n,
    calc_n_core_if.slave bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP2  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t                r_state     [NUM_PORTS];
    state_t                w_state_nxt [NUM_PORTS];
    logic [3:0]            r_cmd       [NUM_PORTS];
    logic [DATA_W-1:0]     r_op1       [NUM_PORTS];
    logic [DATA_W-1:0]     r_op2       [NUM_PORTS];
    logic [3:0]            w_cmd       [NUM_PORTS];
    logic [DATA_W-1:0]     w_din       [NUM_PORTS];

    logic [NUM_PORTS-1:0]        r_busy;
    logic [NUM_PORTS-1:0]        r_drop;
    logic [NUM_PORTS-1:0]        w_drop;
    logic [2*NUM_PORTS-1:0]      r_resp_p1;
    logic [DATA_W*NUM_PORTS-1:0] r_data_p1;
    logic [PTR_W-1:0]            r_last;
    logic [PTR_W-1:0]            w_gnt_idx_p0;
    logic                        w_gnt_vld_p0;
    logic [DATA_W+1:0]           w_alu_p0;
    int                          w_idx;

    // Returns {resp[1:0], data}; overflow/underflow and invalid force data to 0.
    function automatic logic [DATA_W+1:0] alu_f(input logic [3:0]        cmd,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (cmd)
            4'd1:    alu_f = sum[DATA_W] ? {2'b10, {DATA_W{1'b0}}}
                                         : {2'b01, sum[DATA_W-1:0]};
            4'd2:    alu_f = (a < b) ? {2'b10, {DATA_W{1'b0}}}
                                     : {2'b01, a - b};
            4'd5:    alu_f = {2'b01, a << b[SH_W-1:0]};
            4'd6:    alu_f = {2'b01, a >> b[SH_W-1:0]};
            default: alu_f = {2'b11, {DATA_W{1'b0}}};
        endcase
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_cmd[p] = bus.req_cmd_in[4*p +: 4];
            w_din[p] = bus.req_data_in[DATA_W*p +: DATA_W];
        end
    end

    // Stage p0: round-robin pick among PEND ports, starting after the last grant.
    always_comb begin
        w_gnt_vld_p0 = 1'b0;
        w_gnt_idx_p0 = '0;
        w_idx        = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = (int'(r_last) + i) % NUM_PORTS;
            if (!w_gnt_vld_p0 && r_state[w_idx] == S_PEND) begin
                w_gnt_vld_p0 = 1'b1;
                w_gnt_idx_p0 = PTR_W'(w_idx);
            end
        end
    end

    assign w_alu_p0 = alu_f(r_cmd[w_gnt_idx_p0], r_op1[w_gnt_idx_p0], r_op2[w_gnt_idx_p0]);

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_state_nxt[p] = r_state[p];
            w_drop[p]      = (w_cmd[p] != 4'd0) && r_busy[p];
            case (r_state[p])
                S_IDLE:  if (w_cmd[p] != 4'd0) w_state_nxt[p] = S_OP2;
                S_OP2:   w_state_nxt[p] = S_PEND;
                S_PEND:  if (w_gnt_vld_p0 && w_gnt_idx_p0 == PTR_W'(p))
                             w_state_nxt[p] = S_IDLE;
                default: w_state_nxt[p] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) r_state[p] <= S_IDLE;
            r_busy <= '0;
            r_drop <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_state[p] <= w_state_nxt[p];
                r_busy[p]  <= (w_state_nxt[p] != S_IDLE);
            end
            r_drop <= w_drop;
        end
    end

    // Operand capture: data path only, stale contents are harmless in IDLE.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_state[p] == S_IDLE && w_cmd[p] != 4'd0) begin
                r_cmd[p] <= w_cmd[p];
                r_op1[p] <= w_din[p];
            end
            if (r_state[p] == S_OP2) r_op2[p] <= w_din[p];
        end
    end

    // Stage p1: registered response on the granted port's lanes, one cycle only.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_p1 <= '0;
            r_data_p1 <= '0;
            r_last    <= PTR_W'(NUM_PORTS - 1);
        end else begin
            r_resp_p1 <= '0;
            r_data_p1 <= '0;
            if (w_gnt_vld_p0) begin
                r_resp_p1[2*w_gnt_idx_p0 +: 2]           <= w_alu_p0[DATA_W+1:DATA_W];
                r_data_p1[DATA_W*w_gnt_idx_p0 +: DATA_W] <= w_alu_p0[DATA_W-1:0];
                r_last                                   <= w_gnt_idx_p0;
            end
        end
    end

    assign bus.out_resp = r_resp_p1;
    assign bus.out_data = r_data_p1;
    assign bus.busy     = r_busy;
    assign bus.cmd_drop = r_drop;
endmodule

// File: tb/tb_calc_n_core.sv
// Directed bench for calc_n_core (4 ports, 32-bit): ALU cases, arbitration
// order, drop handling and mid-operation reset.
module tb_calc_n_core;
    localparam int NP = 4;
    localparam int DW = 32;

    logic c_clk;
    logic reset_n;
    int   n_cmp;
    int   n_mis;

    calc_n_core_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

    calc_n_core #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .c_clk   (c_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input int p, input logic [1:0] code,
                            input logic [DW-1:0] data);
        logic [2*NP-1:0]  er;
        logic [DW*NP-1:0] ed;
        er = '0;
        ed = '0;
        er[2*p +: 2]   = code;
        ed[DW*p +: DW] = data;
        chk({tag, "_resp"}, 128'(bus.out_resp), 128'(er));
        chk({tag, "_data"}, 128'(bus.out_data), 128'(ed));
    endtask

    task automatic drive(input int p, input logic [3:0] cmd, input logic [DW-1:0] d);
        bus.req_cmd_in[4*p +: 4]    = cmd;
        bus.req_data_in[DW*p +: DW] = d;
    endtask

    task automatic clear_all();
        bus.req_cmd_in  = '0;
        bus.req_data_in = '0;
    endtask

    // Uncontested command: check busy over T+1..T+2, response at T+3, then idle.
    task automatic one_op(input string tag, input int p, input logic [3:0] cmd,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [1:0] er, input logic [DW-1:0] ed);
        drive(p, cmd, a);
        step();
        chk({tag, "_busy1"}, 128'(bus.busy[p]), 128'(1));
        drive(p, 4'd0, b);
        step();
        chk({tag, "_busy2"}, 128'(bus.busy[p]), 128'(1));
        clear_all();
        step();
        chk_resp(tag, p, er, ed);
        chk({tag, "_busy3"}, 128'(bus.busy[p]), 128'(0));
        step();
        chk({tag, "_after"}, 128'(bus.out_resp), 128'(0));
    endtask

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        reset_n = 1'b0;
        clear_all();
        repeat (3) @(posedge c_clk);
        #1;
        chk("rst_resp", 128'(bus.out_resp), 128'(0));
        chk("rst_data", 128'(bus.out_data), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_drop", 128'(bus.cmd_drop), 128'(0));
        reset_n = 1'b1;
        step();

        one_op("add_5_7",     0, 4'd1, 32'h5,         32'h7,  2'b01, 32'hC);
        one_op("add_ovf",     1, 4'd1, 32'hFFFF_FFFF, 32'h1,  2'b10, 32'h0);
        one_op("add_max_0",   1, 4'd1, 32'hFFFF_FFFF, 32'h0,  2'b01, 32'hFFFF_FFFF);
        one_op("sub_3_5",     1, 4'd2, 32'h3,         32'h5,  2'b10, 32'h0);
        one_op("sub_5_3",     1, 4'd2, 32'h5,         32'h3,  2'b01, 32'h2);
        one_op("sub_5_5",     1, 4'd2, 32'h5,         32'h5,  2'b01, 32'h0);
        one_op("shl_1_x24",   2, 4'd5, 32'h1,         32'h24, 2'b01, 32'h10);
        one_op("shr_msb_31",  2, 4'd6, 32'h8000_0000, 32'd31, 2'b01, 32'h1);
        one_op("shl_ovr",     2, 4'd5, 32'hF000_000F, 32'h4,  2'b01, 32'h0000_00F0);
        one_op("inv_3",       2, 4'd3, 32'h1234,      32'h1,  2'b11, 32'h0);
        one_op("inv_F",       3, 4'hF, 32'h1,         32'h1,  2'b11, 32'h0);

        // All four ports at T (port p: (p+1)+0x10); port 0 reissues at T+4.
        for (int p = 0; p < NP; p++) drive(p, 4'd1, DW'(p + 1));
        step();
        for (int p = 0; p < NP; p++) drive(p, 4'd0, 32'h10);
        step();
        clear_all();
        step();
        chk_resp("all_p0", 0, 2'b01, 32'h11);
        chk("all_busy_t3", 128'(bus.busy), 128'(4'b1110));
        step();
        chk_resp("all_p1", 1, 2'b01, 32'h12);
        drive(0, 4'd1, 32'h100);
        step();
        chk_resp("all_p2", 2, 2'b01, 32'h13);
        drive(0, 4'd0, 32'h200);
        step();
        chk_resp("all_p3", 3, 2'b01, 32'h14);
        clear_all();
        step();
        chk_resp("round2_p0", 0, 2'b01, 32'h300);
        step();

        // After a port-1 grant, ports 0 and 2 contend: port 2 goes first.
        one_op("rr_seed", 1, 4'd2, 32'h9, 32'h4, 2'b01, 32'h5);
        drive(0, 4'd1, 32'hA0);
        drive(2, 4'd1, 32'hB0);
        step();
        drive(0, 4'd0, 32'h1);
        drive(2, 4'd0, 32'h2);
        step();
        clear_all();
        step();
        chk_resp("rr_first_p2", 2, 2'b01, 32'hB2);
        step();
        chk_resp("rr_second_p0", 0, 2'b01, 32'hA1);
        step();

        // Port 3: repeated cmd in T+1 and T+2 is dropped; op2 from T+1 is used.
        drive(3, 4'd1, 32'h5);
        step();
        drive(3, 4'd1, 32'h9);
        step();
        chk("drop_t2", 128'(bus.cmd_drop), 128'(4'b1000));
        drive(3, 4'd2, 32'hFFFF);
        step();
        chk_resp("drop_res", 3, 2'b01, 32'hE);
        chk("drop_t3", 128'(bus.cmd_drop), 128'(4'b1000));
        clear_all();
        step();
        chk("drop_t4", 128'(bus.cmd_drop), 128'(0));
        chk("drop_t4_resp", 128'(bus.out_resp), 128'(0));

        // Reset while port 0 is in PEND.
        drive(0, 4'd1, 32'h40);
        step();
        drive(0, 4'd0, 32'h2);
        step();
        clear_all();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_busy", 128'(bus.busy), 128'(0));
        chk("mid_rst_resp", 128'(bus.out_resp), 128'(0));
        chk("mid_rst_data", 128'(bus.out_data), 128'(0));
        @(posedge c_clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("post_rst_none", 128'(bus.out_resp), 128'(0));
        end
        one_op("post_rst_add", 0, 4'd1, 32'h20, 32'h22, 2'b01, 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/calc_n_core.md
# calc_n_core

Parametrised calculator core, the next generation of the four-port calc1 design. It accepts two-operand commands on `NUM_PORTS` independent request ports and captures each operand pair over two cycles. A round-robin arbiter schedules the captured requests onto one shared registered ALU, and the result returns on the issuing port's response lanes. It adds three things calc1 lacks: configurable width and port count, a distinct invalid-command response, and per-port busy and drop signalling.

## Interface
- `NUM_PORTS`, 4: number of request/response ports, 2..16.
- `DATA_W`, 32: operand/result width, power of two, 8..64.
- `SH_W`, $clog2(DATA_W): shift-amount width (derived; not overridden).

- `c_clk`  in  1  core clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_cmd_in`  in  4*NUM_PORTS  per-port command; port p uses bits [4p+3:4p].
- `req_data_in`  in  DATA_W*NUM_PORTS  per-port operand; port p uses bits [DATA_W*p +: DATA_W].
- `out_resp`  out  2*NUM_PORTS  per-port response code, valid for one cycle.
- `out_data`  out  DATA_W*NUM_PORTS  per-port result, valid when the port's `out_resp` != 0, else 0.
- `busy`  out  NUM_PORTS  port has a request in flight.
- `cmd_drop`  out  NUM_PORTS  one-cycle pulse: a command arrived while the port was busy.

## Operation
- Commands: 0 no-op, 1 add, 2 sub, 5 shift left, 6 shift right. Any other nonzero code is invalid.
- Request protocol for port p:
  - Cycle T: cmd != 0 with operand1 on data.
  - Cycle T+1: operand2 on data. The cmd lane is ignored in T+1.
- Per-port FSM:
  - IDLE→OP2 when cmd != 0 and busy = 0; latch cmd and op1.
  - OP2→PEND unconditionally; latch op2.
  - PEND→IDLE at the end of the grant cycle.
- `busy` is registered. It is 1 in the OP2 and PEND states and 0 otherwise.
- A nonzero cmd while busy = 1 is discarded. `cmd_drop[p]` pulses in the next cycle. Data in that cycle is not captured.
- Arbiter:
  - One grant per cycle among ports in PEND, round-robin.
  - Search starts at last-granted + 1, wrapping modulo NUM_PORTS.
  - The last-granted pointer resets to NUM_PORTS-1, so port 0 has first priority.
- ALU, unsigned, DATA_W bits:
  - Add: result = op1+op2 mod 2^DATA_W. Response 01, or 10 with data 0 if a carry-out occurs.
  - Sub: result = op1-op2. Response 01, or 10 with data 0 if op1 < op2.
  - Shift left / shift right: logical shift by op2[SH_W-1:0], zero fill, always response 01. Upper op2 bits are ignored.
  - Invalid command: response 11, data 0.
- Response codes: 00 none, 01 success, 10 overflow/underflow, 11 invalid command.
- Only the granted port's lanes are nonzero in the response cycle. All other lanes stay 00 with data 0.

## Timing
- Reset (async assert, sync-safe deassert handling by integrator):
  - Outputs: `out_resp` = 0, `out_data` = 0, `busy` = 0, `cmd_drop` = 0.
  - State: all FSMs in IDLE, pointer = NUM_PORTS-1.
- Reset mid-operation discards all captured operands. No response is ever produced for them.
- Latency: command in cycle T, response at cycle T+3 when uncontested.
  - Each cycle spent waiting in PEND adds one cycle.
  - Worst case is T+2+NUM_PORTS.
- The response is registered and held for exactly one cycle, then returns to 00/0.
- `busy` rises in T+1 and falls in the response cycle. A new command in the response cycle is accepted.
- Simultaneous commands on all ports in the same cycle T:
  - Responses arrive in consecutive cycles T+3 … T+2+NUM_PORTS.
  - Order follows the round-robin pointer.
- Back-to-back operation on one port sustains at most one command per 3 cycles.
- `cmd_drop` is registered: a drop attempted in cycle X pulses in X+1.

## Test plan
- Port 0, cmd 1, op1 = 0x0000_0005, op2 = 0x0000_0007 (DATA_W=32) -> port 0 resp 01, data 0x0000_000C at T+3; `busy[0]` high T+1..T+2.
- Port 1:
  - cmd 1, 0xFFFF_FFFF + 0x1 -> resp 10, data 0.
  - cmd 2, 3 - 5 -> resp 10, data 0.
  - cmd 2, 5 - 3 -> resp 01, data 2.
- Port 2:
  - cmd 5, op1 0x1, op2 0x24 -> resp 01, data 0x10 (shift by 4).
  - cmd 6, op1 0x8000_0000, op2 31 -> data 1.
  - cmd 3 -> resp 11, data 0.
- All 4 ports issue add in the same cycle T after reset -> responses on ports 0,1,2,3 at T+3,T+4,T+5,T+6. A second round issued in T+4 on port 0 is served in rotated order.
- Port 3 issues cmd 1 at T and again at T+1 -> second command ignored, `cmd_drop[3]` = 1 at T+2, single response at T+3 using op2 = data of T+1.
- `reset_n` low at T+2 with port 0 in PEND -> all outputs 0 immediately; after release no response appears on any port; a new port-0 command completes normally with latency 3.
